// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer.
// Holds the per-channel FSM state encoding and the counter-width helper.
// Imported by debounce_channel and button_debouncer.
package btn_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Width of a counter that must hold values up to max(a,b,c)-1.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 2) m = 2;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-button conditioner: 2-flop synchroniser, debounce FSM, optional auto-repeat.
// Ports: clk, reset (sync, active-high), btn_raw (async raw input),
//        btn_level (debounced, 1 = pressed), btn_press / btn_release (one-cycle pulses).
module debounce_channel
   import btn_pkg::*;
#(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic          IDLE_LVL = (ACTIVE_LOW != 0);
   localparam bit            REP_ON   = (REPEAT_EN != 0);

   logic [1:0]    sync;
   logic          p;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          first_done, first_nxt;
   logic          level_nxt, press_nxt, release_nxt;

   // Synchroniser resets to the released level so reset never looks like a press.
   always_ff @(posedge clk) begin
      if (reset) sync <= {2{IDLE_LVL}};
      else       sync <= {sync[0], btn_raw};
   end

   // Normalise to 1 = pressed regardless of board polarity.
   assign p = IDLE_LVL ? ~sync[1] : sync[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RELEASED;
         cnt         <= '0;
         first_done  <= 1'b0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         first_done  <= first_nxt;
         btn_level   <= level_nxt;
         btn_press   <= press_nxt;
         btn_release <= release_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      first_nxt   = first_done;
      level_nxt   = btn_level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
         RELEASED: begin
            if (p) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!p) begin
               state_nxt = RELEASED;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt = PRESSED;
               level_nxt = 1'b1;
               press_nxt = 1'b1;
               cnt_nxt   = '0;
               first_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         PRESSED: begin
            if (!p) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt   = '0;
            end else if (REP_ON) begin
               // First repeat waits the long delay, later ones the short period.
               if (cnt == (first_done ? PER_LAST : DLY_LAST)) begin
                  press_nxt = 1'b1;
                  cnt_nxt   = '0;
                  first_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         RELEASE_WAIT: begin
            if (p) begin
               // Release bounce: stay logically pressed, no pulse.
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt   = RELEASED;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
               cnt_nxt     = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BUTTONS independent push-button inputs.
// Ports: clk, reset (sync, active-high), btn_raw[NUM_BUTTONS] raw inputs,
//        btn_level / btn_press / btn_release per channel, all registered.
module button_debouncer
   import btn_pkg::*;
#(
   parameter int NUM_BUTTONS     = 2,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] btn_raw,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic [NUM_BUTTONS-1:0] btn_press,
   output logic [NUM_BUTTONS-1:0] btn_release
);

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
      debounce_channel #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .btn_raw     (btn_raw[g]),
         .btn_level   (btn_level[g]),
         .btn_press   (btn_press[g]),
         .btn_release (btn_release[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: table of per-cycle vectors plus
// a hand-written auto-repeat sequence on a second instance.
module tb_button_debouncer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] btn_raw = 2'b11;
   logic [1:0] btn_raw_rep = 2'b11;
   logic [1:0] lvl, prs, rel;
   logic [1:0] lvl_r, prs_r, rel_r;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   button_debouncer #(
      .NUM_BUTTONS(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
   ) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw),
      .btn_level(lvl), .btn_press(prs), .btn_release(rel)
   );

   button_debouncer #(
      .NUM_BUTTONS(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
   ) dut_rep (
      .clk(clk), .reset(reset), .btn_raw(btn_raw_rep),
      .btn_level(lvl_r), .btn_press(prs_r), .btn_release(rel_r)
   );

   typedef struct {
      logic       rst;
      logic [1:0] raw;
      logic [1:0] lvl;
      logic [1:0] prs;
      logic [1:0] rel;
   } vec_t;

   vec_t vecs[256];
   int   nvec = 0;

   task automatic add(input logic r, input logic [1:0] raw, input logic [1:0] l,
                      input logic [1:0] p, input logic [1:0] q, input int n);
      for (int k = 0; k < n; k++) begin
         vecs[nvec] = '{rst: r, raw: raw, lvl: l, prs: p, rel: q};
         nvec++;
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] raw, input logic [1:0] rawr);
      @(negedge clk);
      reset       = r;
      btn_raw     = raw;
      btn_raw_rep = rawr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [1:0] act,
                      input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at step %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   initial begin
      int         n_press, n_rel;
      logic [1:0] exp_p, exp_l, exp_q;
      logic [1:0] rr;

      // Reset state
      add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2);
      // Clean press on channel 0, held 20 cycles
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 6);
      add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 13);
      // Clean release
      add(0, 2'b11, 2'b01, 2'b00, 2'b00, 6);
      add(0, 2'b11, 2'b00, 2'b00, 2'b01, 1);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 3);
      // Both channels together
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 6);
      add(0, 2'b00, 2'b11, 2'b11, 2'b00, 1);
      add(0, 2'b00, 2'b11, 2'b00, 2'b00, 3);
      add(0, 2'b11, 2'b11, 2'b00, 2'b00, 6);
      add(0, 2'b11, 2'b00, 2'b00, 2'b11, 1);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2);
      // Bounce rejection: toggle every 2 cycles for 16 cycles, then released
      for (int k = 0; k < 4; k++) begin
         add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2);
         add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2);
      end
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 4);
      // Then settled pressed
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 6);
      add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 3);
      // Release with bounce: 1,1,0 then 1 held; release 7 edges after final rise
      add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b01, 2'b00, 2'b00, 6);
      add(0, 2'b11, 2'b00, 2'b00, 2'b01, 1);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 3);
      // Reset mid-press
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 6);
      add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2);
      add(1, 2'b10, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 6);
      add(0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 3);
      add(0, 2'b11, 2'b01, 2'b00, 2'b00, 6);
      add(0, 2'b11, 2'b00, 2'b00, 2'b01, 1);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2);

      for (int i = 0; i < nvec; i++) begin
         drive(vecs[i].rst, vecs[i].raw, 2'b11);
         chk("level", i, lvl, vecs[i].lvl);
         chk("press", i, prs, vecs[i].prs);
         chk("release", i, rel, vecs[i].rel);
      end

      // Auto-repeat: hold channel 0 for 60 cycles, then release.
      // Press pulses expected at edges 7, 27, 35, 43, 51, 59; release at 67.
      n_press = 0;
      n_rel   = 0;
      for (int e = 1; e <= 75; e++) begin
         rr = (e <= 60) ? 2'b10 : 2'b11;
         drive(1'b0, 2'b11, rr);
         exp_p = ((e == 7) || (e >= 27 && e <= 59 && ((e - 27) % 8) == 0)) ? 2'b01 : 2'b00;
         exp_l = (e >= 7 && e <= 66) ? 2'b01 : 2'b00;
         exp_q = (e == 67) ? 2'b01 : 2'b00;
         chk("rep_press", e, prs_r, exp_p);
         chk("rep_level", e, lvl_r, exp_l);
         chk("rep_release", e, rel_r, exp_q);
         chk("rep_mutex", e, prs_r & rel_r, 2'b00);
         if (prs_r[0]) n_press++;
         if (rel_r[0]) n_rel++;
      end
      chk("rep_press_count", 0, n_press[1:0] ^ 2'b10, (n_press == 6) ? 2'b00 : 2'b11);
      chk("rep_release_count", 0, n_rel[1:0], 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
